uart_word_tx: RTL and testbench

//  Far end of the core's UART-send path (SWC2). Accepts 32-bit words from the decoder's

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_word_fifo.sv | 53 +++++
 rtl/uart_word_tx.sv | 153 +++++++++++++++
 tb/tb_uart_word_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word transmitter.
// Optional feature macro (used by uart_word_tx): UART_TX_PARITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BITS_PER_BYTE  = 8;

   // Byte idx of a word, counted from the most significant byte
   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[8 * (3 - int'(idx)) +: 8];
   endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO, depth 2**FIFO_AW. Full/empty decode the registered count, so a
// push into a full FIFO is refused even when a pop happens in the same cycle.
module uart_word_fifo
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_AW = 2,
   parameter int unsigned DW      = BYTES_PER_WORD * BITS_PER_BYTE
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int unsigned Depth = 2 ** FIFO_AW;

   logic [DW-1:0]      mem [Depth];
   logic [FIFO_AW-1:0] wr_ptr_q;
   logic [FIFO_AW-1:0] rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               do_push;
   logic               do_pop;

   assign full    = (count_q == (FIFO_AW + 1)'(Depth));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr_q];

   // Pointers wrap naturally; count tracks occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_word_tx.sv
// UART word transmitter: queues 32-bit words and sends each as 4 bytes, MSB byte first,
// LSB bit first, 8N1 (or 8E1 when UART_TX_PARITY_EN is defined).
// txd is registered from the current state, so the line lags the FSM by one cycle.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 868,
   parameter int unsigned FIFO_AW     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        send_ready,
   input  logic [31:0] send_data,
   output logic        send_full,
   output logic        send_drop,
   output logic        tx_busy,
   output logic        txd
);

   localparam int unsigned     CntW     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CntW-1:0] BaudLast = CntW'(CLK_PER_BIT - 1);
   localparam logic [2:0]      LastBit  = 3'(BITS_PER_BYTE - 1);
   localparam logic [1:0]      LastByte = 2'(BYTES_PER_WORD - 1);

   tx_state_t       state_q, state_d;
   logic [CntW-1:0] baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      byte_q, byte_d;
   logic [31:0]     shift_q, shift_d;
   logic            txd_q, txd_d;
   logic            busy_q;
   logic            drop_q;
   logic            baud_done;
   logic [7:0]      cur_byte;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [31:0]     fifo_rdata;

   uart_word_fifo #(
      .FIFO_AW (FIFO_AW),
      .DW      (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (send_ready),
      .wdata (send_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign baud_done = (baud_q == BaudLast);
   assign send_full = fifo_full;
   assign send_drop = drop_q;
   assign tx_busy   = busy_q;
   assign txd       = txd_q;

   // Next-state, baud/bit/byte sequencing, FIFO pop and line level
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      txd_d    = 1'b1;
      cur_byte = word_byte(shift_q, byte_q);
      if (state_q != IDLE) baud_d = baud_done ? '0 : baud_q + 1'b1;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               byte_d   = 2'd0;
               bit_d    = 3'd0;
               state_d  = START;
            end
         end
         START: begin
            txd_d = 1'b0;
            if (baud_done) begin
               bit_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            txd_d = cur_byte[bit_q];
            if (baud_done) begin
               if (bit_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            txd_d = ^cur_byte;
            if (baud_done) state_d = STOP;
         end
`endif
         STOP: begin
            txd_d = 1'b1;
            if (baud_done) begin
               if (byte_q != LastByte) begin
                  byte_d  = byte_q + 2'd1;
                  state_d = START;
               end else if (!fifo_empty) begin
                  // Back-to-back word: no idle gap between frames
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  byte_d   = 2'd0;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= (state_q != IDLE) || !fifo_empty;
         drop_q  <= send_ready && fifo_full;
      end
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx (CLK_PER_BIT=4, FIFO_AW=2). A word-level timing model predicts
// accept/drop and frame start per push; a UART RX model decodes txd into words.
module tb_uart_word_tx;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int WT    = 4 * NB * CPB;
   localparam int LIMIT = 40000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        send_ready = 1'b0;
   logic [31:0] send_data = '0;
   logic        send_full;
   logic        send_drop;
   logic        tx_busy;
   logic        txd;

   uart_word_tx #(
      .CLK_PER_BIT (CPB),
      .FIFO_AW     (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .send_ready (send_ready),
      .send_data  (send_data),
      .send_full  (send_full),
      .send_drop  (send_drop),
      .tx_busy    (tx_busy),
      .txd        (txd)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   int drop_seen = 0;
   int exp_drops = 0;
   int rx_err = 0;

   // Model: frame start edge of each accepted word, and the edge its frame ends
   int          tq[$];
   int          last_end = 0;
   logic [31:0] exp_w[$];
   int          exp_t[$];
   logic [31:0] rx_w[$];
   int          rx_t[$];
   logic        rx_par_q[$];

   always @(negedge clk) if (send_drop === 1'b1) drop_seen++;

   // UART receiver sampling mid-bit on the falling clock edge
   logic        rx_active = 1'b0;
   int          rx_k = 0;
   int          rx_nbytes = 0;
   int          rx_t0 = 0;
   logic [7:0]  rx_byte = '0;
   logic [31:0] rx_word = '0;
   always @(negedge clk) begin
      if (rst) begin
         rx_active = 1'b0;
         rx_nbytes = 0;
      end else if (!rx_active) begin
         if (txd === 1'b0) begin
            rx_active = 1'b1;
            rx_k = 0;
            if (rx_nbytes == 0) rx_t0 = cyc;
         end
      end else begin
         int b;
         rx_k++;
         b = rx_k / CPB;
         if (rx_k % CPB == CPB / 2) begin
            if (b == 0) begin
               if (txd !== 1'b0) rx_err++;
            end else if (b <= 8) begin
               rx_byte[b-1] = txd;
            end else if (b == NB - 1) begin
               if (txd !== 1'b1) rx_err++;
               rx_word = {rx_word[23:0], rx_byte};
               rx_nbytes++;
               if (rx_nbytes == 4) begin
                  rx_w.push_back(rx_word);
                  rx_t.push_back(rx_t0);
                  rx_nbytes = 0;
               end
            end else begin
               rx_par_q.push_back(txd);
               if (txd !== ^rx_byte) rx_err++;
            end
         end
         if (rx_k == CPB * NB - 1) rx_active = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   // Called just after a posedge; the push is sampled at the next edge p
   task automatic push(input logic [31:0] d);
      int   p;
      int   occ;
      logic exp_full;
      p = cyc + 1;
      occ = 0;
      foreach (tq[i]) if (tq[i] >= p) occ++;
      exp_full = (occ == DEPTH);
      send_ready = 1'b1;
      send_data  = d;
      chk("send_full", send_full, exp_full);
      if (exp_full) begin
         exp_drops++;
      end else begin
         int t;
         t = (p + 1 > last_end) ? p + 1 : last_end;
         tq.push_back(t);
         last_end = t + WT;
         exp_w.push_back(d);
         exp_t.push_back(t + 1);
      end
      tick();
      send_ready = 1'b0;
      chk("send_drop", send_drop, exp_full);
   endtask

   task automatic do_reset();
      int r;
      rst = 1'b1;
      r = cyc + 1;
      tick();
      rst = 1'b0;
      while (exp_t.size() > 0 && exp_t[$] - 1 + WT > r) begin
         void'(exp_t.pop_back());
         void'(exp_w.pop_back());
      end
      tq.delete();
      last_end = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((tx_busy !== 1'b0 || cyc <= last_end) && n < LIMIT) begin
         tick();
         n++;
      end
      chk("drain_in_time", n < LIMIT, 1);
      repeat (4) tick();
   endtask

   task automatic check_rx(input string tag);
      logic [31:0] a;
      logic [31:0] e;
      int          ta;
      int          te;
      chk({tag, "_count"}, rx_w.size(), exp_w.size());
      while (rx_w.size() > 0 && exp_w.size() > 0) begin
         a  = rx_w.pop_front();
         e  = exp_w.pop_front();
         ta = rx_t.pop_front();
         te = exp_t.pop_front();
         chk({tag, "_word"}, a, e);
         chk({tag, "_start"}, ta, te);
      end
      rx_w.delete();
      rx_t.delete();
      exp_w.delete();
      exp_t.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, required finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int e;
      int r;
      int gap;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_txd", txd, 1);
      chk("rst_full", send_full, 0);
      chk("rst_drop", send_drop, 0);
      chk("rst_busy", tx_busy, 0);

      // 1: single word, latency and end-of-word timing
      tick();
      p = cyc + 1;
      push(32'h41424344);
      to_neg(p + 1);
      chk("s1_txd_before", txd, 1);
      to_neg(p + 2);
      chk("s1_txd_start", txd, 0);
      to_neg(p + 1 + WT);
      chk("s1_busy_last", tx_busy, 1);
      to_neg(p + 2 + WT);
      chk("s1_busy_low", tx_busy, 0);
      chk("s1_txd_idle", txd, 1);
      tick();
      drain();
      check_rx("s1");

      // 2: burst until full; frames follow back to back
      for (int i = 0; i < 6; i++) push(32'hA5000000 + i);
      drain();
      check_rx("s2");

      // 3: push coinciding with a pop at 3 entries, then fill and overflow
      for (int i = 0; i < 4; i++) push(32'hC0DE0000 + i);
      e = tq[tq.size() - 4] + WT;
      while (cyc < e - 1) tick();
      push(32'hC0DE0004);
      push(32'hC0DE0005);
      push(32'hC0DE0006);
      drain();
      check_rx("s3");

      // 4: reset in the data bits of byte 2 with words queued
      push(32'h11223344);
      push(32'h55667788);
      push(32'h99AABBCC);
      r = tq[tq.size() - 3] + 2 * NB * CPB + CPB + 9;
      while (cyc < r - 1) tick();
      do_reset();
      chk("s4_txd", txd, 1);
      chk("s4_busy", tx_busy, 0);
      chk("s4_full", send_full, 0);
      repeat (WT + 20) tick();
      check_rx("s4_flushed");
      push(32'h000000FF);
      drain();
      check_rx("s4_after");

`ifdef UART_TX_PARITY_EN
      // 5: even parity per byte of 0x01030700
      begin
         logic [3:0] exp_par;
         logic       got;
         exp_par = 4'b1010;
         rx_par_q.delete();
         push(32'h01030700);
         drain();
         check_rx("s5");
         chk("s5_par_count", rx_par_q.size(), 4);
         for (int i = 0; i < 4 && rx_par_q.size() > 0; i++) begin
            got = rx_par_q.pop_front();
            chk("s5_parity", got, exp_par[3-i]);
         end
      end
`endif

      // 6: random words with random gaps against the model
      for (int i = 0; i < 200; i++) begin
         push($urandom);
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 400) : $urandom_range(0, 30);
         repeat (gap) tick();
      end
      drain();
      check_rx("s6");
      chk("drop_count", drop_seen, exp_drops);
      chk("rx_framing", rx_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
